// File: rtl/csr_file_mx.sv
// rtl/csr_file_mx.sv - machine-mode CSR file with 64-bit counters, trap entry and mret
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   csr_valid/op/wen/addr      CSR instruction from EX (op 01 RW, 10 RS, 11 RC, 00 read)
//   csr_wdata                  rs1/zimm operand
//   csr_rdata, csr_illegal     pre-edge value of the addressed CSR, illegal-access flag
//   instr_retire               one instruction retired this cycle
//   trap_valid/is_irq/cause    trap entry request from the trap controller
//   trap_pc, trap_tval         values captured into mepc / mtval on trap entry
//   mret                       return from trap
//   irq_soft/timer/ext         level interrupt sources
//   irq_req_o                  interrupt pending, enabled and globally enabled
//   trap_target_o              next PC when a trap is taken
//   mepc_o, mie_global_o       current mepc and mstatus.MIE
module csr_file_mx #(
    parameter int unsigned      XLEN        = 32,
    parameter logic [XLEN-1:0]  MTVEC_RESET = '0,
    parameter bit               VECTORED_EN = 1'b1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            csr_valid,
    input  logic [1:0]      csr_op,
    input  logic            csr_wen,
    input  logic [11:0]     csr_addr,
    input  logic [XLEN-1:0] csr_wdata,
    output logic [XLEN-1:0] csr_rdata,
    output logic            csr_illegal,
    input  logic            instr_retire,
    input  logic            trap_valid,
    input  logic            trap_is_irq,
    input  logic [4:0]      trap_cause,
    input  logic [XLEN-1:0] trap_pc,
    input  logic [XLEN-1:0] trap_tval,
    input  logic            mret,
    input  logic            irq_soft,
    input  logic            irq_timer,
    input  logic            irq_ext,
    output logic            irq_req_o,
    output logic [XLEN-1:0] trap_target_o,
    output logic [XLEN-1:0] mepc_o,
    output logic            mie_global_o
);
    localparam logic [1:0]      MXL        = (XLEN == 64) ? 2'b10 : 2'b01;
    // MXL in the top two bits, extensions I (bit 8) and M (bit 12)
    localparam logic [XLEN-1:0] MISA       = {MXL, {(XLEN-15){1'b0}}, 13'h1100};
    // mtvec bit 1 is always 0; without vectored support the mode field reads 00
    localparam logic [XLEN-1:0] MTVEC_MASK = VECTORED_EN ? ~XLEN'(2'b10) : ~XLEN'(2'b11);

    logic            mstat_mie_q, mstat_mie_d;
    logic            mstat_mpie_q, mstat_mpie_d;
    logic [2:0]      mie_q, mie_d;          // {MEIE, MTIE, MSIE}
    logic [2:0]      mip_q;                 // {MEIP, MTIP, MSIP}
    logic [XLEN-1:0] mtvec_q, mtvec_d;
    logic [XLEN-1:0] mscratch_q, mscratch_d;
    logic [XLEN-1:0] mepc_q, mepc_d;
    logic [XLEN-1:0] mcause_q, mcause_d;
    logic [XLEN-1:0] mtval_q, mtval_d;
    logic [63:0]     mcycle_q, mcycle_d;
    logic [63:0]     minstret_q, minstret_d;

    logic            impl;
    logic [XLEN-1:0] rd_val;
    logic [XLEN-1:0] wr_new;
    logic            do_wr;
    logic [XLEN-1:0] tvec_base;

    // Read mux: also flags addresses this file does not implement
    always_comb begin
        rd_val = '0;
        impl   = 1'b1;
        case (csr_addr)
            12'h300: rd_val = XLEN'({mstat_mpie_q, 3'b000, mstat_mie_q, 3'b000}) | XLEN'(16'h1800);
            12'h301: rd_val = MISA;
            12'h304: rd_val = XLEN'({mie_q[2], 3'b000, mie_q[1], 3'b000, mie_q[0], 3'b000});
            12'h305: rd_val = mtvec_q;
            12'h340: rd_val = mscratch_q;
            12'h341: rd_val = mepc_q;
            12'h342: rd_val = mcause_q;
            12'h343: rd_val = mtval_q;
            12'h344: rd_val = XLEN'({mip_q[2], 3'b000, mip_q[1], 3'b000, mip_q[0], 3'b000});
            12'hB00: rd_val = mcycle_q[XLEN-1:0];
            12'hB02: rd_val = minstret_q[XLEN-1:0];
            12'hB80: begin
                if (XLEN == 32) rd_val = XLEN'(mcycle_q >> 32);
                else            impl   = 1'b0;
            end
            12'hB82: begin
                if (XLEN == 32) rd_val = XLEN'(minstret_q >> 32);
                else            impl   = 1'b0;
            end
            12'hC00: rd_val = mcycle_q[XLEN-1:0];
            12'hF14: rd_val = '0;
            default: impl   = 1'b0;
        endcase
    end

    assign csr_rdata   = rd_val;
    assign csr_illegal = csr_valid & (~impl | (csr_wen & (csr_addr[11:10] == 2'b11)));

    always_comb begin
        case (csr_op)
            2'b01:   wr_new = csr_wdata;
            2'b10:   wr_new = rd_val | csr_wdata;
            2'b11:   wr_new = rd_val & ~csr_wdata;
            default: wr_new = rd_val;
        endcase
    end

    // Trap and mret win over a CSR write in the same cycle; the write is dropped
    assign do_wr = csr_valid & csr_wen & ~csr_illegal & (csr_op != 2'b00) & ~trap_valid & ~mret;

    always_comb begin
        mstat_mie_d  = mstat_mie_q;
        mstat_mpie_d = mstat_mpie_q;
        mie_d        = mie_q;
        mtvec_d      = mtvec_q;
        mscratch_d   = mscratch_q;
        mepc_d       = mepc_q;
        mcause_d     = mcause_q;
        mtval_d      = mtval_q;
        mcycle_d     = mcycle_q + 64'd1;
        minstret_d   = minstret_q + {63'd0, instr_retire};

        if (trap_valid) begin
            mepc_d       = {trap_pc[XLEN-1:2], 2'b00};
            mcause_d     = {trap_is_irq, {(XLEN-6){1'b0}}, trap_cause};
            mtval_d      = trap_tval;
            mstat_mpie_d = mstat_mie_q;
            mstat_mie_d  = 1'b0;
        end else if (mret) begin
            mstat_mie_d  = mstat_mpie_q;
            mstat_mpie_d = 1'b1;
        end else if (do_wr) begin
            case (csr_addr)
                12'h300: begin
                    mstat_mie_d  = wr_new[3];
                    mstat_mpie_d = wr_new[7];
                end
                12'h304: mie_d      = {wr_new[11], wr_new[7], wr_new[3]};
                12'h305: mtvec_d    = wr_new & MTVEC_MASK;
                12'h340: mscratch_d = wr_new;
                12'h341: mepc_d     = {wr_new[XLEN-1:2], 2'b00};
                12'h342: mcause_d   = wr_new;
                12'h343: mtval_d    = wr_new;
                // A written counter half takes the new value instead of incrementing
                12'hB00: begin
                    mcycle_d = mcycle_q;
                    mcycle_d[XLEN-1:0] = wr_new;
                end
                12'hB02: begin
                    minstret_d = minstret_q;
                    minstret_d[XLEN-1:0] = wr_new;
                end
                12'hB80: mcycle_d   = {wr_new[31:0], mcycle_q[31:0]};
                12'hB82: minstret_d = {wr_new[31:0], minstret_q[31:0]};
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mstat_mie_q  <= 1'b0;
            mstat_mpie_q <= 1'b0;
            mie_q        <= '0;
            mip_q        <= '0;
            mtvec_q      <= MTVEC_RESET & MTVEC_MASK;
            mscratch_q   <= '0;
            mepc_q       <= '0;
            mcause_q     <= '0;
            mtval_q      <= '0;
            mcycle_q     <= '0;
            minstret_q   <= '0;
        end else begin
            mstat_mie_q  <= mstat_mie_d;
            mstat_mpie_q <= mstat_mpie_d;
            mie_q        <= mie_d;
            mip_q        <= {irq_ext, irq_timer, irq_soft};
            mtvec_q      <= mtvec_d;
            mscratch_q   <= mscratch_d;
            mepc_q       <= mepc_d;
            mcause_q     <= mcause_d;
            mtval_q      <= mtval_d;
            mcycle_q     <= mcycle_d;
            minstret_q   <= minstret_d;
        end
    end

    assign tvec_base     = {mtvec_q[XLEN-1:2], 2'b00};
    assign trap_target_o = (mtvec_q[0] && trap_is_irq)
                         ? tvec_base + (XLEN'(trap_cause) << 2)
                         : tvec_base;
    assign irq_req_o     = mstat_mie_q & |(mip_q & mie_q);
    assign mepc_o        = mepc_q;
    assign mie_global_o  = mstat_mie_q;

endmodule

// File: doc/csr_file_mx.md
# csr_file_mx

Parametrised machine-mode CSR file for the RV core: the next generation of the pipeline's control/status register block. It adds selectable XLEN, 64-bit `mcycle`/`minstret` counters, atomic CSRRW/CSRRS/CSRRC read-modify-write, hardware trap entry and `mret` sequencing, and interrupt pending/enable aggregation. It sits beside EX/WB:

- EX issues CSR instructions and reads back the old value.
- The trap controller drives trap entry, `mret` and the interrupt request.

## Interface
- `XLEN`, 32: register width; legal values are 32 and 64.
- `MTVEC_RESET`, 0x0000_0000: reset value of `mtvec`.
- `VECTORED_EN`, 1: when 1, `mtvec` mode 01 (vectored) is honoured; when 0, `mtvec[1:0]` reads 00.

Ports:
- `clk` in 1: clock.
- `rst_n` in 1: asynchronous, active-low reset.
- `csr_valid` in 1: CSR instruction present this cycle.
- `csr_op` in 2: 01 RW, 10 RS, 11 RC; 00 is a read-only access.
- `csr_wen` in 1: the decoder requests a write. It is 0 for CSRRS/RC with rs1=x0.
- `csr_addr` in 12: CSR address.
- `csr_wdata` in XLEN: operand (rs1 or zimm).
- `csr_rdata` out XLEN: old value of the addressed CSR, combinational.
- `csr_illegal` out 1: illegal access, combinational.
- `instr_retire` in 1: one instruction retired this cycle.
- `trap_valid` in 1: take a trap this cycle.
- `trap_is_irq` in 1: the trap is an interrupt.
- `trap_cause` in 5: exception or interrupt code.
- `trap_pc` in XLEN: PC to save in `mepc`.
- `trap_tval` in XLEN: value to save in `mtval`.
- `mret` in 1: execute `mret` this cycle.
- `irq_soft`, `irq_timer`, `irq_ext` in 1 each: level interrupt sources.
- `irq_req_o` out 1: interrupt pending and enabled.
- `trap_target_o` out XLEN: next PC on a trap, combinational.
- `mepc_o` out XLEN: current `mepc`.
- `mie_global_o` out 1: `mstatus.MIE`.

## Operation
Implemented CSRs, with reset values:
- `mstatus` 0x300: only MIE[3], MPIE[7] and MPP[12:11] are kept. MPP is hardwired 11, so the reset value is 0x1800.
- `misa` 0x301: read-only constant, RV32I/RV64I plus M. Writes are ignored without fault.
- `mie` 0x304: only bits 3, 7 and 11 are writable. Resets to 0.
- `mtvec` 0x305: resets to `MTVEC_RESET`. Bit 1 is hardwired 0.
- `mscratch` 0x340, `mcause` 0x342, `mtval` 0x343: reset to 0.
- `mepc` 0x341: resets to 0. Bits [1:0] are forced to 0.
- `mip` 0x344: read-only. Bits 3, 7 and 11 are registered copies of `irq_soft`, `irq_timer` and `irq_ext`. Writes are ignored without fault.
- `mcycle` 0xB00 and `minstret` 0xB02: 64-bit counters. With XLEN=32 these addresses access the low halves, and 0xB80/0xB82 access the high halves.
- `cycle` 0xC00: read-only alias of `mcycle`.
- `mhartid` 0xF14: reads 0.

Illegal access: `csr_illegal` = `csr_valid` AND (the address is unimplemented, OR `csr_wen` targets the 0xC00–0xFFF read-only space, OR XLEN=64 and the address is 0xB80/0xB82). An illegal access causes no state change.

Read-modify-write:
- `csr_rdata` is always the pre-edge value of the addressed CSR.
- The new value is computed from that old value: RW gives wdata, RS gives old | wdata, RC gives old & ~wdata.
- The new value is masked by the CSR's writable bits and written at the clock edge when `csr_valid & csr_wen & ~csr_illegal`.

Trap entry (`trap_valid`), all at one edge:
- `mepc` ← `trap_pc` with bits [1:0] cleared.
- `mcause` ← {`trap_is_irq`, zero-extended `trap_cause`}, with the interrupt flag in bit XLEN-1.
- `mtval` ← `trap_tval`.
- MPIE ← MIE, then MIE ← 0.

`mret`: MIE ← MPIE, MPIE ← 1.

Same-cycle priority: `trap_valid` > `mret` > CSR write. A lower-priority event in the same cycle is dropped entirely; the pipeline guarantees a flush.

Counters:
- `mcycle` increments by 1 every cycle.
- `minstret` increments by 1 when `instr_retire` is high.
- A CSR write to either half of a counter replaces that half, and that counter does not increment in that cycle.
- Both counters wrap from 2^64−1 to 0.

Interrupt request: `irq_req_o` = MIE & |(`mip` & `mie`).

Trap target: if `VECTORED_EN`, `mtvec[0]`=1 and `trap_is_irq`, the target is {`mtvec[XLEN-1:2]`, 00} + 4·`trap_cause`. Otherwise it is {`mtvec[XLEN-1:2]`, 00}. The addition wraps modulo 2^XLEN.

## Timing
- All CSR state updates at the rising edge of `clk`.
- Asserting `rst_n`=0 resets all state immediately, including mid-operation. No write is lost half-applied.
- Reset values are as listed above. After reset, `irq_req_o`=0, `mie_global_o`=0 and `mepc_o`=0.
- `csr_rdata`, `csr_illegal` and `trap_target_o` are combinational from inputs and current state, with zero latency.
- A written value is visible on `csr_rdata` in the next cycle. There is no write-through bypass.
- `mip` lags the irq inputs by 1 cycle, so `irq_req_o` rises 1 cycle after the source rises, given that MIE and the enable bit are set.
- A read of `mcycle` returns the value held before this cycle's increment.

## Test plan
- **Reset:** hold `rst_n`=0, then release. Require `mstatus`=0x1800, `mtvec`=`MTVEC_RESET`, `mcycle`=0. After 10 cycles, `mcycle` reads 10.
- **RMW:** write `mscratch`=0xF0F0 (RW), then RS 0x000F, then RC 0x00F0. The `csr_rdata` sequence is 0, 0xF0F0, 0xF0FF, and the final value is 0xF00F.
- **Trap and return:** set `mtvec`=0x8000_0001, MIE=1, `mie`[7]=1. Raise `irq_timer`. Require `irq_req_o`=1 one cycle later. Then apply trap (irq, cause 7, pc 0x1236). Require `trap_target_o`=0x8000_001C, `mepc`=0x1234, `mcause`=0x8000_0007, MIE=0, MPIE=1. Then `mret`: require MIE=1.
- **Priority:** apply `trap_valid` together with `mret` and a CSR write to `mscratch`. Only the trap effects appear, and `mscratch` is unchanged.
- **Counter wrap (XLEN=32):** write `mcycleh`=0xFFFF_FFFF and `mcycle`=0xFFFF_FFFE. The next reads show a wrap to 0 within 2 cycles. A write-cycle suppresses the increment.
- **Illegal:** write to 0xC00, and access 0x7C0. Both give `csr_illegal`=1 and no state change.
